// File: rtl/n3_lsu.sv
`default_nettype none
// ============================================================================
// Module   : n3_lsu
// Purpose  : In-order load/store queue. Accepts loads/stores from decode,
//            issues them to a request/grant memory port (with a zero-cycle
//            bypass when the queue has nothing pending), and retires them in
//            order on in-order memory responses with load-lane extension.
// Config   : `define LSU_MISALIGN_CHK_EN to flag misaligned half/word accesses
//            at enqueue and retire them with wb_err_o instead of issuing them.
//            Without it, word/half addresses are force-aligned and wb_err_o
//            is tied low.
// Ports    : clk, resetn (async, active-low)
//            ld_v_i/st_v_i, uid_i, rd_i, addr_i, wdata_i, size_i, sext_i
//                                           - enqueue side
//            data_req_o/data_gnt_i, data_we_o, data_addr_o, data_wdata_o,
//            data_wstrb_o, data_ready_i, data_rdata_i
//                                           - memory port
//            wb_v_o, wb_we_o, wb_rd_o, wb_data_o, wb_uid_o, wb_err_o
//                                           - retire/writeback
//            stall_o (free entries <= STALL_MARGIN), ovf_o (sticky overflow)
// Revision : 1.0 - initial release
// ============================================================================
module n3_lsu #(
  parameter int LSQ_DEPTH    = 8,
  parameter int UID_W        = 8,
  parameter int REG_W        = 5,
  parameter int STALL_MARGIN = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ld_v_i,
  input  logic             st_v_i,
  input  logic [UID_W-1:0] uid_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [1:0]       size_i,
  input  logic             sext_i,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  output logic             data_we_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_wdata_o,
  output logic [3:0]       data_wstrb_o,
  input  logic             data_ready_i,
  input  logic [31:0]      data_rdata_i,
  output logic             wb_v_o,
  output logic             wb_we_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic [UID_W-1:0] wb_uid_o,
  output logic             wb_err_o,
  output logic             stall_o,
  output logic             ovf_o
);

  localparam int c_IDX_W = $clog2(LSQ_DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;
  localparam logic [c_PTR_W-1:0] c_DEPTH  = c_PTR_W'(LSQ_DEPTH);
  localparam logic [c_PTR_W-1:0] c_MARGIN = c_PTR_W'(STALL_MARGIN);

  // --------------------------------------------------------------------------
  // Data formatting helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] f_store_data(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd2:    f_store_data = {4{d[7:0]}};
      2'd1:    f_store_data = {2{d[15:0]}};
      default: f_store_data = d;
    endcase
  endfunction

  function automatic logic [3:0] f_strobe(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd2:    f_strobe = 4'b0001 << a;
      2'd1:    f_strobe = a[1] ? 4'b1100 : 4'b0011;
      default: f_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_load_data(input logic [31:0] d, input logic [1:0] a,
                                              input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'd2:    f_load_data = {{24{sx & b[7]}}, b};
      2'd1:    f_load_data = {{16{sx & h[15]}}, h};
      default: f_load_data = d;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Pointers and queue storage
  // --------------------------------------------------------------------------
  logic [c_PTR_W-1:0] r_wr, r_iss, r_rd;
  logic               r_ovf;

  logic               r_q_we   [LSQ_DEPTH];
  logic [UID_W-1:0]   r_q_uid  [LSQ_DEPTH];
  logic [REG_W-1:0]   r_q_rd   [LSQ_DEPTH];
  logic [31:0]        r_q_addr [LSQ_DEPTH];
  logic [31:0]        r_q_wdata[LSQ_DEPTH];
  logic [1:0]         r_q_size [LSQ_DEPTH];
  logic               r_q_sext [LSQ_DEPTH];

  logic [c_IDX_W-1:0] w_wr_idx, w_iss_idx, w_rd_idx;
  logic [c_PTR_W-1:0] w_occ, w_free;
  logic               w_full, w_enq_v, w_enq, w_iss_empty, w_bypass;
  logic               w_issue, w_ret, w_err_ret;
  logic [31:0]        w_in_addr;

  assign w_wr_idx    = r_wr[c_IDX_W-1:0];
  assign w_iss_idx   = r_iss[c_IDX_W-1:0];
  assign w_rd_idx    = r_rd[c_IDX_W-1:0];
  assign w_occ       = r_wr - r_rd;
  assign w_full      = (w_occ == c_DEPTH);
  assign w_free      = c_DEPTH - w_occ;
  assign w_enq_v     = ld_v_i | st_v_i;
  assign w_enq       = w_enq_v & ~w_full;
  assign w_iss_empty = (r_iss == r_wr);
  // Nothing queued ahead of the incoming request: present it to memory
  // straight from the inputs.
  assign w_bypass    = w_iss_empty & w_enq;

  always_comb begin
    w_in_addr = addr_i;
`ifndef LSU_MISALIGN_CHK_EN
    if (size_i == 2'd0) begin
      w_in_addr[1:0] = 2'b00;
    end else if (size_i == 2'd1) begin
      w_in_addr[0] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_we[w_wr_idx]    <= st_v_i;
      r_q_uid[w_wr_idx]   <= uid_i;
      r_q_rd[w_wr_idx]    <= rd_i;
      r_q_addr[w_wr_idx]  <= w_in_addr;
      r_q_wdata[w_wr_idx] <= wdata_i;
      r_q_size[w_wr_idx]  <= size_i;
      r_q_sext[w_wr_idx]  <= sext_i;
    end
  end

  // --------------------------------------------------------------------------
  // Misalignment handling
  // --------------------------------------------------------------------------
  logic w_p_mis;

`ifdef LSU_MISALIGN_CHK_EN
  logic r_q_mis [LSQ_DEPTH];
  logic w_in_mis, w_err_set, r_err_pend;

  assign w_in_mis = ((size_i == 2'd0) && (addr_i[1:0] != 2'b00)) ||
                    ((size_i == 2'd1) && addr_i[0]);
  assign w_p_mis  = w_bypass ? w_in_mis : r_q_mis[w_iss_idx];
  // A flagged entry at the issue point only retires once every earlier
  // request has been answered, so the response stream stays in order.
  assign w_err_set = ~r_err_pend & (r_iss == r_rd) & ~w_iss_empty & r_q_mis[w_iss_idx];

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_mis[w_wr_idx] <= w_in_mis;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_pend <= 1'b0;
    end else begin
      r_err_pend <= w_err_set;
    end
  end

  assign w_err_ret = r_err_pend;
`else
  assign w_p_mis   = 1'b0;
  assign w_err_ret = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Memory request port
  // --------------------------------------------------------------------------
  logic              w_p_we;
  logic [31:0]       w_p_addr, w_p_wdata;
  logic [1:0]        w_p_size;

  assign w_p_we    = w_bypass ? st_v_i    : r_q_we[w_iss_idx];
  assign w_p_addr  = w_bypass ? w_in_addr : r_q_addr[w_iss_idx];
  assign w_p_wdata = w_bypass ? wdata_i   : r_q_wdata[w_iss_idx];
  assign w_p_size  = w_bypass ? size_i    : r_q_size[w_iss_idx];

  assign data_req_o   = (~w_iss_empty | w_enq) & ~w_p_mis;
  assign data_we_o    = w_p_we;
  assign data_addr_o  = w_p_addr;
  assign data_wdata_o = f_store_data(w_p_wdata, w_p_size);
  assign data_wstrb_o = w_p_we ? f_strobe(w_p_addr[1:0], w_p_size) : 4'b0000;
  assign w_issue      = data_req_o & data_gnt_i;

  // --------------------------------------------------------------------------
  // Retire / writeback (responses only count while something is in flight)
  // --------------------------------------------------------------------------
  assign w_ret     = data_ready_i & (r_iss != r_rd);
  assign wb_v_o    = w_ret | w_err_ret;
  assign wb_we_o   = w_ret & ~r_q_we[w_rd_idx];
  assign wb_err_o  = w_err_ret;
  assign wb_rd_o   = r_q_rd[w_rd_idx];
  assign wb_uid_o  = r_q_uid[w_rd_idx];
  assign wb_data_o = wb_we_o ? f_load_data(data_rdata_i, r_q_addr[w_rd_idx][1:0],
                                           r_q_size[w_rd_idx], r_q_sext[w_rd_idx])
                             : 32'd0;

  assign stall_o = (w_free <= c_MARGIN);
  assign ovf_o   = r_ovf;

  // --------------------------------------------------------------------------
  // Pointer and flag state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_iss <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_wr  <= r_wr  + c_PTR_W'(w_enq);
      r_iss <= r_iss + c_PTR_W'(w_issue | w_err_ret);
      r_rd  <= r_rd  + c_PTR_W'(w_ret | w_err_ret);
      r_ovf <= r_ovf | (w_enq_v & w_full);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_n3_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_n3_lsu
// Purpose  : Self-checking bench for n3_lsu. A queue-based behavioural model
//            predicts every output each cycle; directed sequences pin the
//            model with hand-computed literals, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n3_lsu;

  localparam int DEPTH  = 8;
  localparam int UW     = 8;
  localparam int RW     = 5;
  localparam int MARGIN = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ld_v_i, st_v_i, sext_i, data_gnt_i, data_ready_i;
  logic [UW-1:0] uid_i;
  logic [RW-1:0] rd_i;
  logic [31:0]   addr_i, wdata_i, data_rdata_i;
  logic [1:0]    size_i;
  logic          data_req_o, data_we_o, wb_v_o, wb_we_o, wb_err_o, stall_o, ovf_o;
  logic [31:0]   data_addr_o, data_wdata_o, wb_data_o;
  logic [3:0]    data_wstrb_o;
  logic [RW-1:0] wb_rd_o;
  logic [UW-1:0] wb_uid_o;

  always #5 clk = ~clk;

  n3_lsu #(.LSQ_DEPTH(DEPTH), .UID_W(UW), .REG_W(RW), .STALL_MARGIN(MARGIN)) dut (
    .clk(clk), .resetn(resetn),
    .ld_v_i(ld_v_i), .st_v_i(st_v_i), .uid_i(uid_i), .rd_i(rd_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i), .sext_i(sext_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_wstrb_o(data_wstrb_o),
    .data_ready_i(data_ready_i), .data_rdata_i(data_rdata_i),
    .wb_v_o(wb_v_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_uid_o(wb_uid_o), .wb_err_o(wb_err_o), .stall_o(stall_o), .ovf_o(ovf_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: list of not-yet-retired entries in program order, plus
  // a count of how many of them (from the front) have been granted.
  // --------------------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [UW-1:0] uid;
    logic [RW-1:0] rd;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [1:0]    size;
    logic          sext;
    logic          mis;
  } ent_t;

  ent_t q[$];
  int   n_iss  = 0;
  bit   m_ovf  = 0;
  bit   m_pend = 0;

  function automatic ent_t mk_in();
    ent_t e;
    e.we = st_v_i; e.uid = uid_i; e.rd = rd_i; e.wdata = wdata_i;
    e.size = size_i; e.sext = sext_i; e.addr = addr_i; e.mis = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    e.mis = (size_i == 2'd0 && addr_i % 4 != 0) || (size_i == 2'd1 && addr_i % 2 != 0);
`else
    if (size_i == 2'd0) e.addr = addr_i & ~32'd3;
    else if (size_i == 2'd1) e.addr = addr_i & ~32'd1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] exp_wdata(ent_t e);
    if (e.size == 2'd2) return {24'd0, e.wdata[7:0]} * 32'h01010101;
    if (e.size == 2'd1) return {16'd0, e.wdata[15:0]} * 32'h00010001;
    return e.wdata;
  endfunction

  function automatic logic [3:0] exp_strb(ent_t e);
    if (!e.we) return 4'b0000;
    if (e.size == 2'd2) return 4'(1 << (e.addr % 4));
    if (e.size == 2'd1) return (e.addr % 4 >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_load(ent_t e, logic [31:0] rdata);
    int          bits;
    logic [31:0] v, mask;
    bits = (e.size == 2'd2) ? 8 : (e.size == 2'd1) ? 16 : 32;
    v = rdata >> (8 * (e.addr % 4));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (e.sext && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Single compare process: checks at mid-cycle, then advances the model to
  // what the coming rising edge will produce (inputs are stable until then).
  initial begin
    ent_t pe, hd;
    bit   has, req, enq_ok, ret_ok, err_ret, set_pend;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        q.delete(); n_iss = 0; m_ovf = 0; m_pend = 0;
      end
      enq_ok  = (ld_v_i || st_v_i) && q.size() < DEPTH;
      has     = 0;
      if (n_iss < q.size()) begin pe = q[n_iss]; has = 1; end
      else if (enq_ok) begin pe = mk_in(); has = 1; end
      req     = has && !pe.mis;
      ret_ok  = data_ready_i && n_iss > 0;
      err_ret = m_pend;

      check("req", data_req_o, req);
      if (req) begin
        check("req_we", data_we_o, pe.we);
        check("req_addr", data_addr_o, pe.addr);
        check("req_strb", data_wstrb_o, exp_strb(pe));
        if (pe.we) check("req_wdata", data_wdata_o, exp_wdata(pe));
      end
      check("wb_v", wb_v_o, ret_ok || err_ret);
      if (ret_ok || err_ret) begin
        hd = q[0];
        check("wb_uid", wb_uid_o, hd.uid);
        check("wb_rd", wb_rd_o, hd.rd);
        check("wb_we", wb_we_o, ret_ok && !hd.we);
        check("wb_err", wb_err_o, err_ret);
        check("wb_data", wb_data_o, (ret_ok && !hd.we) ? exp_load(hd, data_rdata_i) : 32'd0);
      end
      check("stall", stall_o, (DEPTH - q.size()) <= MARGIN);
      check("ovf", ovf_o, m_ovf);

      if (resetn) begin
        set_pend = !m_pend && n_iss == 0 && q.size() > 0 && q[0].mis;
        if ((ld_v_i || st_v_i) && !enq_ok) m_ovf = 1;
        if (enq_ok) q.push_back(mk_in());
        if (req && data_gnt_i) n_iss++;
        if (ret_ok) begin void'(q.pop_front()); n_iss--; end
        if (err_ret) void'(q.pop_front());
        m_pend = set_pend;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_v_i = 0; st_v_i = 0; uid_i = '0; rd_i = '0; addr_i = '0; wdata_i = '0;
    size_i = 2'd0; sext_i = 0; data_gnt_i = 0; data_ready_i = 0; data_rdata_i = '0;
  endtask

  task automatic drive(input logic st, input logic [UW-1:0] uid, input logic [RW-1:0] rd,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sx);
    ld_v_i = ~st; st_v_i = st; uid_i = uid; rd_i = rd; addr_i = addr;
    wdata_i = wd; size_i = sz; sext_i = sx;
  endtask

  int uid_ctr = 100;

  task automatic rand_phase(input int cycles, input int p_enq, input int p_gnt, input int p_rdy);
    for (int c = 0; c < cycles; c++) begin
      tick(); idle();
      if ($urandom_range(0, 99) < p_enq) begin
        drive(1'($urandom_range(0, 1)), UW'(uid_ctr), RW'($urandom), $urandom, $urandom,
              2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        uid_ctr++;
      end
      data_gnt_i   = ($urandom_range(0, 99) < p_gnt);
      data_ready_i = ($urandom_range(0, 99) < p_rdy);
      data_rdata_i = $urandom;
    end
  endtask

  initial begin
    int n;
    int nreq, n_ok, n_err;
    idle();
    resetn = 0;
    tick(); tick();
    @(negedge clk);
    check("rst_req", data_req_o, 0);
    check("rst_wbv", wb_v_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_ovf", ovf_o, 0);
    tick(); resetn = 1;

    // Word load through the zero-cycle bypass.
    tick(); idle(); drive(0, 8'd1, 5'd3, 32'h100, 32'd0, 2'd0, 0); data_gnt_i = 1;
    @(negedge clk);
    check("t20_req", data_req_o, 1);
    check("t20_addr", data_addr_o, 32'h100);
    tick(); idle(); data_ready_i = 1; data_rdata_i = 32'h80000001;
    @(negedge clk);
    check("t20_wbv", wb_v_o, 1);
    check("t20_wbwe", wb_we_o, 1);
    check("t20_data", wb_data_o, 32'h80000001);
    check("t20_rd", wb_rd_o, 3);

    // Byte store then sign-extended byte load at lane 3.
    tick(); idle(); drive(1, 8'd2, 5'd0, 32'h103, 32'hA5, 2'd2, 0); data_gnt_i = 1;
    @(negedge clk);
    check("t21_wdata", data_wdata_o, 32'hA5A5A5A5);
    check("t21_strb", data_wstrb_o, 4'b1000);
    tick(); idle(); data_ready_i = 1;
    @(negedge clk);
    check("t21_st_wbv", wb_v_o, 1);
    check("t21_st_wbwe", wb_we_o, 0);
    tick(); idle(); drive(0, 8'd3, 5'd7, 32'h103, 32'd0, 2'd2, 1); data_gnt_i = 1;
    tick(); idle(); data_ready_i = 1; data_rdata_i = 32'hA5000000;
    @(negedge clk);
    check("t21_lb", wb_data_o, 32'hFFFFFFA5);

    // Fill with no grants: stall at free <= 2, overflow on the 9th.
    for (int k = 0; k < 9; k++) begin
      tick(); idle(); drive(0, UW'(10 + k), RW'(k), 32'h200 + 32'(4 * k), 32'd0, 2'd0, 0);
      @(negedge clk);
      check("t22_stall", stall_o, k >= 6);
      check("t22_ovf_pre", ovf_o, 0);
    end
    tick(); idle();
    @(negedge clk);
    check("t22_ovf", ovf_o, 1);
    check("t22_stall_full", stall_o, 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick(); idle(); data_gnt_i = 1; data_ready_i = 1;
      @(negedge clk);
      if (wb_v_o) begin check("t22_uid", wb_uid_o, 10 + n); n++; end
    end
    check("t22_count", n, 8);

    // Back-to-back enqueue/grant/ready across pointer wrap.
    n = 0;
    for (int k = 0; k < 21; k++) begin
      tick(); idle();
      if (k < 20) drive(0, UW'(k), RW'(k), 32'h300 + 32'(4 * k), 32'd0, 2'd0, 0);
      data_gnt_i = 1; data_ready_i = 1; data_rdata_i = 32'(k);
      @(negedge clk);
      if (wb_v_o) begin check("t23_uid", wb_uid_o, n); n++; end
    end
    check("t23_count", n, 20);

`ifdef LSU_MISALIGN_CHK_EN
    tick(); idle(); drive(0, 8'd40, 5'd1, 32'h100, 32'd0, 2'd0, 0);
    tick(); idle(); drive(0, 8'd41, 5'd2, 32'h102, 32'd0, 2'd0, 0); data_gnt_i = 1;
    nreq = 0; n_ok = 0; n_err = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); idle(); data_gnt_i = 1; data_ready_i = 1;
      @(negedge clk);
      if (data_req_o) nreq++;
      if (wb_v_o) begin
        if (wb_err_o) begin check("t24_err_uid", wb_uid_o, 41); n_err++; end
        else begin check("t24_ok_uid", wb_uid_o, 40); n_ok++; end
      end
    end
    check("t24_nreq", nreq, 0);
    check("t24_ok", n_ok, 1);
    check("t24_err", n_err, 1);
`endif

    // Reset with three requests in flight.
    for (int k = 0; k < 3; k++) begin
      tick(); idle(); drive(0, UW'(50 + k), RW'(k), 32'h400, 32'd0, 2'd0, 0); data_gnt_i = 1;
    end
    tick(); idle(); resetn = 0;
    @(negedge clk);
    check("t25_req", data_req_o, 0);
    check("t25_wbv", wb_v_o, 0);
    check("t25_stall", stall_o, 0);
    check("t25_ovf", ovf_o, 0);
    tick(); resetn = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); idle(); data_ready_i = 1;
      @(negedge clk);
      check("t25_wbv_after", wb_v_o, 0);
    end

    rand_phase(400, 45, 60, 55);
    rand_phase(200, 70, 15, 30);
    rand_phase(200, 30, 80, 80);
    tick(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
